core_bridge_cmd_engine: RTL and testbench

Parametrised host/target command engine on the APF bridge, mapped at 0xF8xxxxxx. Host commands are decoded from the bridge mailbox and dispatched to core logic through a generic valid/done handshake; only Request Status is answered internally. Target-to-host commands come from a queue of depth `TQ_DEPTH`, with a per-command response timeout. Register width and depth are generalised through parameters.

---
 rtl/core_bridge_cmd_engine.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_core_bridge_cmd_engine.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bridge_cmd_engine.sv
// core_bridge_cmd_engine: APF bridge command engine at 0xF8xxxxxx.
// Host commands dispatch to core logic; target commands come from a queue.
module core_bridge_cmd_engine #(
    parameter int          PARAM_WORDS    = 4,
    parameter int          RESP_WORDS     = 4,
    parameter int          TQ_DEPTH       = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bridge_endian_little,
    input  logic [31:0]               bridge_addr,
    input  logic                      bridge_rd,
    input  logic                      bridge_wr,
    input  logic [31:0]               bridge_wr_data,
    output logic [31:0]               bridge_rd_data,
    input  logic                      status_boot_done,
    input  logic                      status_setup_done,
    input  logic                      status_running,
    output logic                      host_cmd_valid,
    output logic [15:0]               host_cmd_id,
    output logic [32*PARAM_WORDS-1:0] host_param,
    input  logic                      host_cmd_done,
    input  logic [15:0]               host_cmd_result,
    input  logic [32*RESP_WORDS-1:0]  host_resp,
    input  logic                      targ_push,
    input  logic [15:0]               targ_push_id,
    input  logic [32*PARAM_WORDS-1:0] targ_push_param,
    output logic                      targ_full,
    output logic                      targ_overflow,
    output logic                      targ_done,
    output logic                      targ_timeout,
    output logic [15:0]               targ_result,
    output logic [32*RESP_WORDS-1:0]  targ_resp
);

    localparam int PB = 32 * PARAM_WORDS;
    localparam int RB = 32 * RESP_WORDS;
    localparam int QW = $clog2(TQ_DEPTH);
    localparam logic [QW:0]   Q_FULL = (QW+1)'(TQ_DEPTH);
    localparam logic [QW:0]   Q_ONE  = (QW+1)'(1);
    localparam logic [QW-1:0] P_ONE  = QW'(1);
    localparam logic [3:0]    PW     = 4'(PARAM_WORDS);
    localparam logic [3:0]    RW     = 4'(RESP_WORDS);

    localparam logic [1:0] H_IDLE  = 2'd0;
    localparam logic [1:0] H_PARSE = 2'd1;
    localparam logic [1:0] H_WAIT  = 2'd2;
    localparam logic [1:0] H_DONE  = 2'd3;
    localparam logic [0:0] T_IDLE  = 1'b0;
    localparam logic [0:0] T_WAIT  = 1'b1;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Address decode; bits [23:16] are don't-care inside the 0xF8 window
    logic        unused_addr;
    logic        f8_sel, h_sel, t_sel, par_hit, resp_hit;
    logic [7:0]  off;
    logic [2:0]  widx;
    logic [31:0] wdata, rd_val;
    logic [2:0]  endian_q;
    logic        little;

    assign unused_addr = ^bridge_addr[23:16];
    assign off      = bridge_addr[7:0];
    assign widx     = off[4:2];
    assign f8_sel   = bridge_addr[31:24] == 8'hF8;
    assign h_sel    = f8_sel && bridge_addr[15:8] == 8'h00;
    assign t_sel    = f8_sel && bridge_addr[15:8] == 8'h10;
    assign par_hit  = off[7:5] == 3'b001 && off[1:0] == 2'b00 && {1'b0, widx} < PW;
    assign resp_hit = off[7:5] == 3'b010 && off[1:0] == 2'b00 && {1'b0, widx} < RW;
    assign little   = endian_q[2];
    assign wdata    = little ? bswap(bridge_wr_data) : bridge_wr_data;

    // Host side state
    logic [1:0]    hstate_q, hstate_d;
    logic [31:0]   host0_q, host0_d;
    logic [15:0]   hcmd_q, hcmd_d, hres_q, hres_d, stat_code;
    logic          hvalid_q, hvalid_d;
    logic [PB-1:0] hpar_q, hpar_d;
    logic [RB-1:0] hresp_q, hresp_d;

    // Target side state
    logic [0:0]    tstate_q, tstate_d;
    logic [31:0]   targ0_q, targ0_d, timer_q, timer_d;
    logic [15:0]   tres_q, tres_d;
    logic [RB-1:0] tresp_q, tresp_d, twr_q, twr_d;
    logic [PB-1:0] tpar_q, tpar_d;
    logic          tdone_q, tdone_d, tto_q, tto_d, pop;

    // Queue state
    logic [15:0]   qid_q  [TQ_DEPTH];
    logic [PB-1:0] qpar_q [TQ_DEPTH];
    logic [QW-1:0] wptr_q, rptr_q;
    logic [QW:0]   count_q, count_d;
    logic          full, do_push, auto_push, ovf_q;
    logic          setup_q, pend_q;
    logic [15:0]   push_id;
    logic [PB-1:0] push_par;
    logic [31:0]   rd_data_q;

    assign full      = count_q == Q_FULL;
    assign auto_push = pend_q && !targ_push && !full;
    assign do_push   = (targ_push && !full) || auto_push;
    assign push_id   = targ_push ? targ_push_id : 16'h0140;
    assign push_par  = targ_push ? targ_push_param : '0;

    // Request Status answer from the core status lines
    always_comb begin
        stat_code = 16'd2;
        if (!status_boot_done)      stat_code = 16'd1;
        else if (status_setup_done) stat_code = 16'd3;
        else if (status_running)    stat_code = 16'd4;
    end

    // Host command FSM next state
    always_comb begin
        hstate_d = hstate_q;
        host0_d  = host0_q;
        hcmd_d   = hcmd_q;
        hres_d   = hres_q;
        hvalid_d = hvalid_q;
        hpar_d   = hpar_q;
        hresp_d  = hresp_q;
        if (bridge_wr && h_sel && par_hit && hstate_q == H_IDLE)
            hpar_d[32*widx +: 32] = wdata;
        unique case (hstate_q)
            H_IDLE: begin
                if (bridge_wr && h_sel && off == 8'h00 && wdata[31:16] == 16'h434D) begin
                    hcmd_d   = wdata[15:0];
                    hstate_d = H_PARSE;
                end
            end
            H_PARSE: begin
                host0_d = {16'h4255, hcmd_q};
                if (hcmd_q == 16'h0000) begin
                    hres_d   = stat_code;
                    hstate_d = H_DONE;
                end else begin
                    hvalid_d = 1'b1;
                    hstate_d = H_WAIT;
                end
            end
            H_WAIT: begin
                if (host_cmd_done) begin
                    hres_d   = host_cmd_result;
                    hresp_d  = host_resp;
                    hvalid_d = 1'b0;
                    hstate_d = H_DONE;
                end
            end
            default: begin
                host0_d  = {16'h4F4B, hres_q};
                hstate_d = H_IDLE;
            end
        endcase
    end

    // Target command FSM next state; ack takes priority over timeout
    always_comb begin
        tstate_d = tstate_q;
        targ0_d  = targ0_q;
        timer_d  = timer_q;
        tres_d   = tres_q;
        tresp_d  = tresp_q;
        tpar_d   = tpar_q;
        twr_d    = twr_q;
        tdone_d  = 1'b0;
        tto_d    = 1'b0;
        pop      = 1'b0;
        if (bridge_wr && t_sel && off == 8'h00)
            targ0_d = wdata;
        if (bridge_wr && t_sel && resp_hit)
            twr_d[32*widx +: 32] = wdata;
        unique case (tstate_q)
            T_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    tpar_d   = qpar_q[rptr_q];
                    targ0_d  = {16'h636D, qid_q[rptr_q]};
                    timer_d  = '0;
                    tstate_d = T_WAIT;
                end
            end
            default: begin
                if (targ0_q[31:16] == 16'h6F6B) begin
                    tres_d   = targ0_q[15:0];
                    tresp_d  = twr_q;
                    tdone_d  = 1'b1;
                    tstate_d = T_IDLE;
                end else if (TIMEOUT_CYCLES != '0 &&
                             timer_q + 32'd1 == TIMEOUT_CYCLES) begin
                    targ0_d  = '0;
                    tto_d    = 1'b1;
                    tstate_d = T_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
        endcase
    end

    // Queue occupancy; full is judged before this cycle's pop
    always_comb begin
        count_d = count_q;
        if (do_push && !pop)      count_d = count_q + Q_ONE;
        else if (!do_push && pop) count_d = count_q - Q_ONE;
    end

    // Read data mux over both windows
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            h_sel && off == 8'h00: rd_val = host0_q;
            h_sel && off == 8'h04: rd_val = 32'h20;
            h_sel && off == 8'h08: rd_val = 32'h40;
            h_sel && resp_hit:     rd_val = hresp_q[32*widx +: 32];
            t_sel && off == 8'h00: rd_val = targ0_q;
            t_sel && off == 8'h04: rd_val = 32'h20;
            t_sel && off == 8'h08: rd_val = 32'h40;
            t_sel && par_hit:      rd_val = tpar_q[32*widx +: 32];
            default:               rd_val = '0;
        endcase
    end

    // Queue storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) begin
            qid_q[wptr_q]  <= push_id;
            qpar_q[wptr_q] <= push_par;
        end
    end

    // All control and visible registers
    always_ff @(posedge clk) begin
        if (reset) begin
            endian_q  <= '0;
            hstate_q  <= H_IDLE;
            host0_q   <= '0;
            hcmd_q    <= '0;
            hres_q    <= '0;
            hvalid_q  <= 1'b0;
            hpar_q    <= '0;
            hresp_q   <= '0;
            tstate_q  <= T_IDLE;
            targ0_q   <= '0;
            timer_q   <= '0;
            tres_q    <= '0;
            tresp_q   <= '0;
            tpar_q    <= '0;
            twr_q     <= '0;
            tdone_q   <= 1'b0;
            tto_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            setup_q   <= 1'b0;
            pend_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            endian_q  <= {endian_q[1:0], bridge_endian_little};
            hstate_q  <= hstate_d;
            host0_q   <= host0_d;
            hcmd_q    <= hcmd_d;
            hres_q    <= hres_d;
            hvalid_q  <= hvalid_d;
            hpar_q    <= hpar_d;
            hresp_q   <= hresp_d;
            tstate_q  <= tstate_d;
            targ0_q   <= targ0_d;
            timer_q   <= timer_d;
            tres_q    <= tres_d;
            tresp_q   <= tresp_d;
            tpar_q    <= tpar_d;
            twr_q     <= twr_d;
            tdone_q   <= tdone_d;
            tto_q     <= tto_d;
            count_q   <= count_d;
            ovf_q     <= targ_push && full;
            setup_q   <= status_setup_done;
            pend_q    <= (pend_q && !auto_push) || (status_setup_done && !setup_q);
            if (do_push) wptr_q <= wptr_q + P_ONE;
            if (pop)     rptr_q <= rptr_q + P_ONE;
            if (bridge_rd)
                rd_data_q <= little ? bswap(rd_val) : rd_val;
        end
    end

    assign bridge_rd_data = rd_data_q;
    assign host_cmd_valid = hvalid_q;
    assign host_cmd_id    = hcmd_q;
    assign host_param     = hpar_q;
    assign targ_full      = full;
    assign targ_overflow  = ovf_q;
    assign targ_done      = tdone_q;
    assign targ_timeout   = tto_q;
    assign targ_result    = tres_q;
    assign targ_resp      = tresp_q;

endmodule

// File: tb/tb_core_bridge_cmd_engine.sv
// tb_core_bridge_cmd_engine: directed bench for the bridge command engine.
// Host status/dispatch, target ack/timeout/overflow, endianness and reset.
module tb_core_bridge_cmd_engine;

    localparam logic [31:0] HOST0 = 32'hF800_0000;
    localparam logic [31:0] TARG0 = 32'hF800_1000;

    logic         clk = 1'b0;
    logic         reset;
    logic         bridge_endian_little;
    logic [31:0]  bridge_addr;
    logic         bridge_rd;
    logic         bridge_wr;
    logic [31:0]  bridge_wr_data;
    logic [31:0]  bridge_rd_data;
    logic         status_boot_done;
    logic         status_setup_done;
    logic         status_running;
    logic         host_cmd_valid;
    logic [15:0]  host_cmd_id;
    logic [127:0] host_param;
    logic         host_cmd_done;
    logic [15:0]  host_cmd_result;
    logic [127:0] host_resp;
    logic         targ_push;
    logic [15:0]  targ_push_id;
    logic [127:0] targ_push_param;
    logic         targ_full;
    logic         targ_overflow;
    logic         targ_done;
    logic         targ_timeout;
    logic [15:0]  targ_result;
    logic [127:0] targ_resp;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int n_done = 0;
    int n_to   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (targ_done)    n_done++;
        if (targ_timeout) n_to++;
    end

    core_bridge_cmd_engine #(
        .PARAM_WORDS(4),
        .RESP_WORDS(4),
        .TQ_DEPTH(4),
        .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bridge_endian_little(bridge_endian_little),
        .bridge_addr(bridge_addr),
        .bridge_rd(bridge_rd),
        .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data),
        .bridge_rd_data(bridge_rd_data),
        .status_boot_done(status_boot_done),
        .status_setup_done(status_setup_done),
        .status_running(status_running),
        .host_cmd_valid(host_cmd_valid),
        .host_cmd_id(host_cmd_id),
        .host_param(host_param),
        .host_cmd_done(host_cmd_done),
        .host_cmd_result(host_cmd_result),
        .host_resp(host_resp),
        .targ_push(targ_push),
        .targ_push_id(targ_push_id),
        .targ_push_param(targ_push_param),
        .targ_full(targ_full),
        .targ_overflow(targ_overflow),
        .targ_done(targ_done),
        .targ_timeout(targ_timeout),
        .targ_result(targ_result),
        .targ_resp(targ_resp)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bwr(input logic [31:0] a, input logic [31:0] d);
        bridge_addr    = a;
        bridge_wr_data = d;
        bridge_wr      = 1'b1;
        cyc();
        bridge_wr      = 1'b0;
    endtask

    task automatic brd(input logic [31:0] a, output logic [31:0] d);
        bridge_addr = a;
        bridge_rd   = 1'b1;
        cyc();
        bridge_rd   = 1'b0;
        d = bridge_rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) cyc();
        checks++;
        if (bridge_rd_data !== 32'h0) begin
            errors++; $display("FAIL rst_rd_data: got %h want 0", bridge_rd_data);
        end
        checks++;
        if (host_cmd_valid !== 1'b0 || host_cmd_id !== 16'h0) begin
            errors++; $display("FAIL rst_host: got v=%b id=%h want 0", host_cmd_valid, host_cmd_id);
        end
        checks++;
        if ({targ_full, targ_overflow, targ_done, targ_timeout} !== 4'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 0000",
                {targ_full, targ_overflow, targ_done, targ_timeout});
        end
        checks++;
        if (targ_result !== 16'h0 || targ_resp !== '0 || host_param !== '0) begin
            errors++; $display("FAIL rst_data: got res=%h want 0", targ_result);
        end
        reset = 1'b0;
        cyc();
        brd(HOST0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_host0: got %h want 0", d); end
        brd(TARG0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_targ0: got %h want 0", d); end
        brd(HOST0 | 32'h4, d);
        checks++;
        if (d !== 32'h20) begin errors++; $display("FAIL host_04: got %h want 20", d); end
        brd(TARG0 | 32'h8, d);
        checks++;
        if (d !== 32'h40) begin errors++; $display("FAIL targ_08: got %h want 40", d); end
        brd(32'hF800_2000, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", d); end
    endtask

    task automatic test_status_cmd();
        logic [31:0] d;
        status_boot_done  = 1'b1;
        status_setup_done = 1'b0;
        status_running    = 1'b0;
        bwr(HOST0, 32'h434D_0000);
        brd(HOST0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL stat_p1: got %h want 0", d); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h4255_0000) begin errors++; $display("FAIL stat_p2: got %h want 42550000", d); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h4F4B_0002) begin errors++; $display("FAIL stat_p3: got %h want 4f4b0002", d); end
        checks++;
        if (host_cmd_valid !== 1'b0) begin errors++; $display("FAIL stat_novalid: got %b want 0", host_cmd_valid); end
        bwr(32'hF900_0000, 32'h434D_0080);
        repeat (3) cyc();
        checks++;
        if (host_cmd_valid !== 1'b0) begin errors++; $display("FAIL unmapped_wr: got %b want 0", host_cmd_valid); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h4F4B_0002) begin errors++; $display("FAIL unmapped_host0: got %h want 4f4b0002", d); end
    endtask

    task automatic test_dispatch();
        logic [31:0] d;
        bwr(HOST0 | 32'h20, 32'd5);
        bwr(HOST0, 32'h434D_0080);
        checks++;
        if (host_cmd_valid !== 1'b0) begin errors++; $display("FAIL disp_early: got %b want 0", host_cmd_valid); end
        cyc();
        checks++;
        if (host_cmd_valid !== 1'b1 || host_cmd_id !== 16'h0080) begin
            errors++; $display("FAIL disp_valid: got v=%b id=%h want 1 0080", host_cmd_valid, host_cmd_id);
        end
        checks++;
        if (host_param[63:0] !== 64'h5) begin errors++; $display("FAIL disp_param: got %h want 5", host_param[63:0]); end
        bwr(HOST0, 32'h434D_0001);
        bwr(HOST0 | 32'h20, 32'd9);
        cyc();
        checks++;
        if (host_cmd_id !== 16'h0080 || host_param[31:0] !== 32'd5 || host_cmd_valid !== 1'b1) begin
            errors++; $display("FAIL disp_hold: got id=%h p=%h want 0080 5", host_cmd_id, host_param[31:0]);
        end
        host_cmd_result = 16'd2;
        host_resp       = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
        host_cmd_done   = 1'b1;
        cyc();
        host_cmd_done   = 1'b0;
        checks++;
        if (host_cmd_valid !== 1'b0) begin errors++; $display("FAIL disp_drop: got %b want 0", host_cmd_valid); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h4255_0080) begin errors++; $display("FAIL disp_busy: got %h want 42550080", d); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h4F4B_0002) begin errors++; $display("FAIL disp_ok: got %h want 4f4b0002", d); end
        brd(HOST0 | 32'h40, d);
        checks++;
        if (d !== 32'hAA) begin errors++; $display("FAIL disp_resp0: got %h want aa", d); end
        brd(HOST0 | 32'h44, d);
        checks++;
        if (d !== 32'hBB) begin errors++; $display("FAIL disp_resp1: got %h want bb", d); end
        brd(HOST0 | 32'h20, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL param_wo: got %h want 0", d); end
    endtask

    task automatic test_target_ack();
        logic [31:0] d;
        int done0;
        done0 = n_done;
        status_setup_done = 1'b1;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            brd(TARG0, d);
            if (d == 32'h636D_0140) break;
        end
        checks++;
        if (d !== 32'h636D_0140) begin errors++; $display("FAIL targ_setup: got %h want 636d0140", d); end
        brd(TARG0 | 32'h20, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL targ_param0: got %h want 0", d); end
        bwr(TARG0 | 32'h40, 32'h11);
        bwr(TARG0, 32'h6F6B_0000);
        checks++;
        if (targ_done !== 1'b0) begin errors++; $display("FAIL ack_early: got %b want 0", targ_done); end
        cyc();
        checks++;
        if (targ_done !== 1'b1 || targ_result !== 16'h0) begin
            errors++; $display("FAIL ack_pulse: got d=%b r=%h want 1 0", targ_done, targ_result);
        end
        checks++;
        if (targ_resp[31:0] !== 32'h11) begin errors++; $display("FAIL ack_resp: got %h want 11", targ_resp[31:0]); end
        repeat (4) cyc();
        checks++;
        if (n_done - done0 !== 1 || n_to !== 0) begin
            errors++; $display("FAIL ack_count: got done=%0d to=%0d want 1 0", n_done - done0, n_to);
        end
    endtask

    task automatic test_overflow_timeout();
        logic [31:0] d;
        int tprev;
        int w;
        targ_push_id    = 16'h0A00;
        targ_push_param = 128'h0A00;
        targ_push       = 1'b1;
        cyc();
        targ_push       = 1'b0;
        repeat (2) cyc();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                checks++;
                if (targ_full !== 1'b1 || targ_overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_full: got f=%b o=%b want 1 0", targ_full, targ_overflow);
                end
            end
            targ_push_id    = 16'h0A00 + 16'(k);
            targ_push_param = {112'h0, 16'h0A00 + 16'(k)};
            targ_push       = 1'b1;
            cyc();
        end
        targ_push = 1'b0;
        checks++;
        if (targ_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", targ_overflow); end
        cyc();
        checks++;
        if (targ_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", targ_overflow); end
        w = 0;
        while (!targ_timeout && w < 60) begin cyc(); w++; end
        checks++;
        if (targ_timeout !== 1'b1) begin errors++; $display("FAIL to_blocker: got %b want 1", targ_timeout); end
        tprev = cyc_n;
        for (int k = 1; k <= 4; k++) begin
            brd(TARG0, d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL to_clear%0d: got %h want 0", k, d); end
            brd(TARG0, d);
            checks++;
            if (d !== {16'h636D, 16'h0A00 + 16'(k)}) begin
                errors++; $display("FAIL to_order%0d: got %h want 636d0a0%0d", k, d, k);
            end
            brd(TARG0 | 32'h20, d);
            checks++;
            if (d !== {16'h0, 16'h0A00 + 16'(k)}) begin
                errors++; $display("FAIL to_param%0d: got %h want 00000a0%0d", k, d, k);
            end
            w = 0;
            while (!targ_timeout && w < 60) begin cyc(); w++; end
            checks++;
            if (targ_timeout !== 1'b1 || cyc_n - tprev != 17) begin
                errors++; $display("FAIL to_gap%0d: got pulse=%b gap=%0d want 1 17", k, targ_timeout, cyc_n - tprev);
            end
            tprev = cyc_n;
        end
        brd(TARG0, d);
        brd(TARG0, d);
        checks++;
        if (d !== 32'h0 || targ_full !== 1'b0) begin
            errors++; $display("FAIL to_drop5: got %h f=%b want 0 0", d, targ_full);
        end
    endtask

    task automatic test_endian();
        logic [31:0] d;
        bridge_endian_little = 1'b1;
        repeat (4) cyc();
        bwr(HOST0, 32'h0000_4D43);
        brd(HOST0, d);
        brd(HOST0, d);
        checks++;
        if (d !== 32'h0000_5542) begin errors++; $display("FAIL end_busy: got %h want 00005542", d); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h0300_4B4F) begin errors++; $display("FAIL end_ok: got %h want 03004b4f", d); end
        brd(HOST0 | 32'h4, d);
        checks++;
        if (d !== 32'h2000_0000) begin errors++; $display("FAIL end_04: got %h want 20000000", d); end
        bridge_endian_little = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset_wait();
        logic [31:0] d;
        int done0;
        int to0;
        bwr(HOST0 | 32'h20, 32'h77);
        bwr(HOST0, 32'h434D_0099);
        for (int k = 1; k <= 5; k++) begin
            targ_push_id    = 16'h0B00 + 16'(k);
            targ_push_param = 128'h0;
            targ_push       = 1'b1;
            cyc();
        end
        targ_push = 1'b0;
        brd(TARG0, d);
        checks++;
        if (d !== 32'h636D_0B01 || targ_full !== 1'b1 || host_cmd_valid !== 1'b1) begin
            errors++; $display("FAIL pre_rst: got %h f=%b v=%b want 636d0b01 1 1", d, targ_full, host_cmd_valid);
        end
        done0 = n_done;
        to0   = n_to;
        reset = 1'b1;
        cyc();
        checks++;
        if (bridge_rd_data !== 32'h0 || host_cmd_valid !== 1'b0 || host_cmd_id !== 16'h0) begin
            errors++; $display("FAIL mid_rst_host: got rd=%h v=%b id=%h want 0", bridge_rd_data, host_cmd_valid, host_cmd_id);
        end
        checks++;
        if (host_param !== '0 || targ_resp !== '0 || targ_result !== 16'h0) begin
            errors++; $display("FAIL mid_rst_data: got p=%h r=%h want 0", host_param[31:0], targ_resp[31:0]);
        end
        checks++;
        if ({targ_full, targ_overflow, targ_done, targ_timeout} !== 4'b0) begin
            errors++; $display("FAIL mid_rst_flags: got %b want 0000",
                {targ_full, targ_overflow, targ_done, targ_timeout});
        end
        status_setup_done = 1'b0;
        cyc();
        reset = 1'b0;
        repeat (30) cyc();
        checks++;
        if (n_done != done0 || n_to != to0) begin
            errors++; $display("FAIL rst_pulses: got done=%0d to=%0d want 0 0", n_done - done0, n_to - to0);
        end
        brd(TARG0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_rst_targ0: got %h want 0", d); end
        brd(HOST0, d);
        checks++;
        if (d !== 32'h0 || host_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_host0: got %h v=%b want 0 0", d, host_cmd_valid);
        end
    endtask

    initial begin
        reset                = 1'b1;
        bridge_endian_little = 1'b0;
        bridge_addr          = '0;
        bridge_rd            = 1'b0;
        bridge_wr            = 1'b0;
        bridge_wr_data       = '0;
        status_boot_done     = 1'b0;
        status_setup_done    = 1'b0;
        status_running       = 1'b0;
        host_cmd_done        = 1'b0;
        host_cmd_result      = '0;
        host_resp            = '0;
        targ_push            = 1'b0;
        targ_push_id         = '0;
        targ_push_param      = '0;
        #1;
        test_reset();
        test_status_cmd();
        test_dispatch();
        test_target_ack();
        test_overflow_timeout();
        test_endian();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
